memory_arbiter: RTL and testbench

Shares the CPU's single memory block among several requesters: port 0 is the CPU fetch/load path, and the higher ports serve devices such as the UART tx engine or a DMA engine. Each cycle it grants at most one request using round-robin selection. It drives the memory block's read and write ports and steers the one-cycle-latency read data back to the port that issued the read. It sits between the CPU core and `memory_block`, replacing the CPU's direct connection to memory.

---
 rtl/ucisc_pkg.sv | 17 +
 rtl/memory_arbiter_rr_select.sv | 44 ++++
 rtl/memory_arbiter.sv | 155 +++++++++++++++
 tb/tb_memory_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ucisc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ucisc_pkg
// Description : Shared constants for the uCISC memory subsystem: default
//               address/data widths, the CPU port index and the largest
//               requester count the memory arbiter supports.
// Revision    : 1.0 - initial release
// ============================================================================
package ucisc_pkg;

    localparam int ADDR_WIDTH_DEF = 16;
    localparam int DATA_WIDTH_DEF = 16;
    localparam int PORT_CPU       = 0;
    localparam int MAX_PORTS      = 8;

endpackage : ucisc_pkg
`default_nettype wire

// File: rtl/memory_arbiter_rr_select.sv
`default_nettype none
// ============================================================================
// Module      : rr_select
// Description : Combinational rotating-priority picker. The search begins at
//               the port after last_grant and wraps; the first valid port
//               gets the one-hot grant. A single-bit valid vector therefore
//               passes straight through, which the arbiter uses for its lock
//               and CPU-priority overrides.
// Ports       : valid      - request vector
//               last_grant - index of the previous winner
//               grant      - one-hot grant (all zero when nothing is valid)
// Revision    : 1.0 - initial release
// ============================================================================
module rr_select #(
    parameter int NUM_PORTS = 3,
    parameter int IDX_W     = 2
) (
    input  logic [NUM_PORTS-1:0] valid,
    input  logic [IDX_W-1:0]     last_grant,
    output logic [NUM_PORTS-1:0] grant
);

    logic found;

    // Two passes: ports above last_grant first, then the wrapped range.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (!found && valid[p] && (IDX_W'(p) > last_grant)) begin
                grant[p] = 1'b1;
                found    = 1'b1;
            end
        end
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (!found && valid[p] && (IDX_W'(p) <= last_grant)) begin
                grant[p] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule : rr_select
`default_nettype wire

// File: rtl/memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : memory_arbiter
// Description : Shares the single memory block between NUM_PORTS requesters
//               (port 0 = CPU) with round-robin arbitration, an optional
//               per-port lock, and one-cycle read-response steering.
// Macro       : ARB_CPU_PRIORITY_EN - port 0 wins whenever valid (unless
//               another port holds the lock); ports 1..N-1 round-robin.
// Ports       : clock/reset (async, active-low)
//               req_valid/req_write/req_lock/req_addr/req_wdata - requests
//               req_ready  - one-hot grant
//               resp_valid/resp_data - read response (T+1 after grant)
//               mem_*      - memory block read/write ports
// Revision    : 1.0 - initial release
// ============================================================================
module memory_arbiter
    import ucisc_pkg::*;
#(
    parameter int NUM_PORTS  = 3,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [NUM_PORTS-1:0]             req_valid,
    input  logic [NUM_PORTS-1:0]             req_write,
    input  logic [NUM_PORTS-1:0]             req_lock,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  req_wdata,
    output logic [NUM_PORTS-1:0]             req_ready,
    output logic [NUM_PORTS-1:0]             resp_valid,
    output logic [DATA_WIDTH-1:0]            resp_data,
    output logic [ADDR_WIDTH-1:0]            mem_read_address,
    output logic                             mem_write_enable,
    output logic [ADDR_WIDTH-1:0]            mem_write_address,
    output logic [DATA_WIDTH-1:0]            mem_data_in,
    input  logic [DATA_WIDTH-1:0]            mem_data_out
);

    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic [IDX_W-1:0]      last_grant;
    logic [IDX_W-1:0]      lock_owner;
    logic [IDX_W-1:0]      resp_port;
    logic                  locked;
    logic                  resp_pending;
    logic [ADDR_WIDTH-1:0] held_addr;

    logic [NUM_PORTS-1:0]  owner_mask;
    logic [NUM_PORTS-1:0]  sel_valid;
    logic [NUM_PORTS-1:0]  grant;
    logic [IDX_W-1:0]      win_idx;
    logic                  any_grant;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  sel_write;
    logic                  sel_lock;

    // Candidate set: a lock narrows it to the owner; in priority mode a valid
    // CPU narrows it to port 0 and otherwise port 0 is excluded from the ring.
    always_comb begin
        owner_mask = '0;
        owner_mask[lock_owner] = 1'b1;
        if (locked) begin
            sel_valid = req_valid & owner_mask;
        end else begin
`ifdef ARB_CPU_PRIORITY_EN
            if (req_valid[PORT_CPU]) begin
                sel_valid = '0;
                sel_valid[PORT_CPU] = 1'b1;
            end else begin
                sel_valid = req_valid;
                sel_valid[PORT_CPU] = 1'b0;
            end
`else
            sel_valid = req_valid;
`endif
        end
    end

    rr_select #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_rr_select (
        .valid      (sel_valid),
        .last_grant (last_grant),
        .grant      (grant)
    );

    // No grant may be issued while reset is held low.
    assign req_ready = reset ? grant : '0;
    assign any_grant = |req_ready;

    always_comb begin
        win_idx   = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_write = 1'b0;
        sel_lock  = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (req_ready[p]) begin
                win_idx   = IDX_W'(p);
                sel_addr  = req_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = req_wdata[p*DATA_WIDTH +: DATA_WIDTH];
                sel_write = req_write[p];
                sel_lock  = req_lock[p];
            end
        end
    end

    assign mem_read_address  = any_grant ? sel_addr : held_addr;
    assign mem_write_address = any_grant ? sel_addr : held_addr;
    assign mem_data_in       = sel_wdata;
    assign mem_write_enable  = any_grant & sel_write;

    always_comb begin
        resp_valid = '0;
        if (resp_pending) begin
            resp_valid[resp_port] = 1'b1;
        end
    end

    assign resp_data = mem_data_out;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_grant   <= IDX_W'(NUM_PORTS - 1);
            locked       <= 1'b0;
            lock_owner   <= '0;
            resp_pending <= 1'b0;
            resp_port    <= '0;
            held_addr    <= '0;
        end else begin
            resp_pending <= any_grant & ~sel_write;
            if (any_grant) begin
                resp_port  <= win_idx;
                held_addr  <= sel_addr;
                locked     <= sel_lock;
                lock_owner <= win_idx;
`ifdef ARB_CPU_PRIORITY_EN
                if (win_idx != IDX_W'(PORT_CPU)) begin
                    last_grant <= win_idx;
                end
`else
                last_grant <= win_idx;
`endif
            end else if (locked) begin
                // Owner dropped valid: release the lock without re-arbitrating.
                locked <= 1'b0;
            end
        end
    end

endmodule : memory_arbiter
`default_nettype wire

// File: tb/tb_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_memory_arbiter
// Description : Self-checking bench for memory_arbiter with a behavioural
//               memory block and a rule-level reference model of grants,
//               locking and read responses. Honours ARB_CPU_PRIORITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_arbiter;

    localparam int N  = 3;
    localparam int AW = 16;
    localparam int DW = 16;

    logic              clock;
    logic              reset;
    logic [N-1:0]      req_valid, req_write, req_lock;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_wdata;
    logic [N-1:0]      req_ready, resp_valid;
    logic [DW-1:0]     resp_data;
    logic [AW-1:0]     mem_read_address, mem_write_address;
    logic              mem_write_enable;
    logic [DW-1:0]     mem_data_in, mem_data_out;

    memory_arbiter #(.NUM_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clock             (clock),
        .reset             (reset),
        .req_valid         (req_valid),
        .req_write         (req_write),
        .req_lock          (req_lock),
        .req_addr          (req_addr),
        .req_wdata         (req_wdata),
        .req_ready         (req_ready),
        .resp_valid        (resp_valid),
        .resp_data         (resp_data),
        .mem_read_address  (mem_read_address),
        .mem_write_enable  (mem_write_enable),
        .mem_write_address (mem_write_address),
        .mem_data_in       (mem_data_in),
        .mem_data_out      (mem_data_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural memory block: synchronous read, one-cycle latency.
    logic [DW-1:0] mem [0:255];
    always @(posedge clock) begin
        if (mem_write_enable) mem[mem_write_address[7:0]] <= mem_data_in;
        mem_data_out <= mem[mem_read_address[7:0]];
    end

    // Requester-side stimulus state.
    logic          v_valid [N];
    logic          v_write [N];
    logic          v_lock  [N];
    logic [AW-1:0] v_addr  [N];
    logic [DW-1:0] v_wdata [N];

    // Reference model state.
    logic [DW-1:0] ref_mem [0:255];
    int            m_last, m_owner, m_port;
    bit            m_locked, m_pending;
    logic [DW-1:0] m_rdata;
    logic [AW-1:0] m_haddr;

    int n_tests = 0;
    int n_fail  = 0;
    int last_w;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        m_last    = N - 1;
        m_locked  = 1'b0;
        m_owner   = 0;
        m_pending = 1'b0;
        m_port    = 0;
        m_rdata   = '0;
        m_haddr   = '0;
    endtask

    function automatic int model_winner();
        if (m_locked) return v_valid[m_owner] ? m_owner : -1;
`ifdef ARB_CPU_PRIORITY_EN
        if (v_valid[0]) return 0;
`endif
        for (int k = 1; k <= N; k++) begin
            int p;
            p = (m_last + k) % N;
`ifdef ARB_CPU_PRIORITY_EN
            if (p != 0 && v_valid[p]) return p;
`else
            if (v_valid[p]) return p;
`endif
        end
        return -1;
    endfunction

    task automatic set_idle();
        for (int p = 0; p < N; p++) begin
            v_valid[p] = 1'b0; v_write[p] = 1'b0; v_lock[p] = 1'b0;
            v_addr[p]  = '0;   v_wdata[p] = '0;
        end
    endtask

    task automatic drive();
        for (int p = 0; p < N; p++) begin
            req_valid[p] = v_valid[p];
            req_write[p] = v_write[p];
            req_lock[p]  = v_lock[p];
            req_addr[p*AW +: AW]  = v_addr[p];
            req_wdata[p*DW +: DW] = v_wdata[p];
        end
    endtask

    // One clock cycle: drive at the falling edge, check just after, then
    // advance the model to the state it will have after the rising edge.
    task automatic step();
        int w;
        @(negedge clock);
        drive();
        #1;
        w = model_winner();
        chk("req_ready", 32'(req_ready), (w >= 0) ? (32'd1 << w) : 32'd0);
        chk("resp_valid", 32'(resp_valid), m_pending ? (32'd1 << m_port) : 32'd0);
        if (m_pending) chk("resp_data", 32'(resp_data), 32'(m_rdata));
        chk("rd_addr", 32'(mem_read_address),  32'((w >= 0) ? v_addr[w] : m_haddr));
        chk("wr_addr", 32'(mem_write_address), 32'((w >= 0) ? v_addr[w] : m_haddr));
        chk("we", 32'(mem_write_enable), 32'((w >= 0) && v_write[w]));
        if (w >= 0) chk("wdata", 32'(mem_data_in), 32'(v_wdata[w]));
        if (w >= 0) begin
`ifdef ARB_CPU_PRIORITY_EN
            if (w != 0) m_last = w;
`else
            m_last = w;
`endif
            m_locked = v_lock[w];
            m_owner  = w;
            m_haddr  = v_addr[w];
            if (v_write[w]) begin
                ref_mem[v_addr[w][7:0]] = v_wdata[w];
                m_pending = 1'b0;
            end else begin
                m_pending = 1'b1;
                m_port    = w;
                m_rdata   = ref_mem[v_addr[w][7:0]];
            end
        end else begin
            m_locked  = 1'b0;
            m_pending = 1'b0;
        end
        last_w = w;
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_ready"},  32'(req_ready), 32'd0);
        chk({tag, "_resp"},   32'(resp_valid), 32'd0);
        chk({tag, "_raddr"},  32'(mem_read_address), 32'd0);
        chk({tag, "_waddr"},  32'(mem_write_address), 32'd0);
        chk({tag, "_we"},     32'(mem_write_enable), 32'd0);
    endtask

    initial begin
        logic [AW-1:0] base [N];
        for (int i = 0; i < 256; i++) begin
            mem[i]     <= DW'(i * 16'h0123 + 16'h0F0F);
            ref_mem[i]  = DW'(i * 16'h0123 + 16'h0F0F);
        end
        base[0] = 16'h0010; base[1] = 16'h0020; base[2] = 16'h0030;

        // Reset with every port requesting: nothing may be granted.
        reset = 1'b0;
        model_reset();
        set_idle();
        for (int p = 0; p < N; p++) begin
            v_valid[p] = 1'b1; v_addr[p] = base[p];
        end
        drive();
        #7;
        reset_checks("rst");
        for (int p = 0; p < N; p++) v_valid[p] = 1'b0;
        @(negedge clock);
        drive();
        reset = 1'b1;

        // All three ports reading continuously.
        for (int p = 0; p < N; p++) begin
            v_valid[p] = 1'b1; v_addr[p] = base[p];
        end
        for (int i = 0; i < 6; i++) begin
            step();
`ifndef ARB_CPU_PRIORITY_EN
            chk("rr_order", 32'(last_w), 32'(i % N));
`endif
        end

        // Five idle cycles.
        set_idle();
        for (int i = 0; i < 5; i++) step();

        // Write then read-after-write on port 1.
        v_valid[1] = 1'b1; v_write[1] = 1'b1; v_addr[1] = 16'h0040; v_wdata[1] = 16'hBEEF;
        step();
        v_write[1] = 1'b0;
        step();
        set_idle();
        step();
        chk("raw_data",  32'(resp_data),  32'h0000BEEF);
        chk("raw_valid", 32'(resp_valid), 32'b010);

        // Port 2 locks for three transfers while the CPU waits.
        v_valid[0] = 1'b1; v_addr[0] = 16'h0011;
        v_valid[2] = 1'b1; v_addr[2] = 16'h0050; v_lock[2] = 1'b1;
        step();
`ifndef ARB_CPU_PRIORITY_EN
        chk("lock_g1", 32'(last_w), 32'd2);
`endif
        step();
        v_lock[2] = 1'b0;
        step();
        v_valid[2] = 1'b0;
        step();
        chk("lock_rel", 32'(last_w), 32'd0);

        // Ports 0 and 1 continuous, then port 0 drops out.
        set_idle();
        v_valid[0] = 1'b1; v_valid[1] = 1'b1; v_addr[0] = 16'h0012; v_addr[1] = 16'h0022;
        for (int i = 0; i < 4; i++) step();
        v_valid[0] = 1'b0;
        step();
        chk("p1_alone", 32'(last_w), 32'd1);

        // Reset asserted while a read response is pending.
        set_idle();
        v_valid[0] = 1'b1; v_addr[0] = 16'h0013;
        step();
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        reset_checks("midrst_a");
        @(posedge clock);
        #1;
        reset_checks("midrst_b");
        set_idle();
        @(negedge clock);
        drive();
        reset = 1'b1;
        for (int p = 0; p < N; p++) begin
            v_valid[p] = 1'b1; v_addr[p] = base[p];
        end
        step();
        chk("post_rst_first", 32'(last_w), 32'd0);

        // Randomised traffic with requesters holding until granted.
        for (int i = 0; i < 400; i++) begin
            for (int p = 0; p < N; p++) begin
                if (!v_valid[p] || last_w == p) begin
                    v_valid[p] = ($urandom_range(0, 99) < 60);
                    v_write[p] = 1'($urandom_range(0, 1));
                    v_lock[p]  = ($urandom_range(0, 9) < 2);
                    v_addr[p]  = AW'($urandom_range(0, 15));
                    v_wdata[p] = DW'($urandom);
                end
            end
            step();
        end
        set_idle();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_memory_arbiter
`default_nettype wire
